// File: rtl/i2s_pkg.sv
`default_nettype none
// ============================================================================
// Module      : i2s_pkg
// Description : I2S framing constants and frame bit counter type.
// Revision    : 1.0 - initial release
// ============================================================================
package i2s_pkg;

    localparam int I2S_SLOT_BITS  = 32;
    localparam int I2S_FRAME_BITS = 64;

    typedef logic [$clog2(I2S_FRAME_BITS)-1:0] bcnt_t;

endpackage
`default_nettype wire

// File: rtl/sample_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sample_pkg
// Description : Stereo audio sample type shared across the pedal pipeline.
// Revision    : 1.0 - initial release
// ============================================================================
package sample_pkg;

    localparam int SAMPLE_WIDTH = 24;

    typedef struct packed {
        logic signed [SAMPLE_WIDTH-1:0] lc;
        logic signed [SAMPLE_WIDTH-1:0] rc;
    } stereo_t;

endpackage
`default_nettype wire

// File: rtl/axis_if.sv
`default_nettype none
// ============================================================================
// Module      : axis_if
// Description : Stereo-sample AXI-stream style handshake (vld/ok).
// Revision    : 1.0 - initial release
// ============================================================================
interface axis_if;
    import sample_pkg::*;

    stereo_t data;
    logic    vld;
    logic    ok;

    modport slave  (input  data, input  vld, output ok);
    modport master (output data, output vld, input  ok);

endinterface
`default_nettype wire

// File: rtl/i2s_clkgen.sv
`default_nettype none
// ============================================================================
// Module      : i2s_clkgen
// Description : I2S master bit/word clock generator with frame bit counter.
// Revision    : 1.0 - initial release
// ============================================================================
module i2s_clkgen
    import i2s_pkg::*;
#(
    parameter int SCLK_HALF = 2
) (
    input  logic  clk,
    input  logic  rst,
    output logic  sclk,
    output logic  lrck,
    output bcnt_t bcnt,
    output logic  fall,
    output logic  frame_start
);

    localparam int c_DIV_W = (SCLK_HALF > 1) ? $clog2(SCLK_HALF) : 1;

    logic [c_DIV_W-1:0] r_div;
    logic               r_sclk;
    logic               r_lrck;
    bcnt_t              r_bcnt;
    logic               w_tc;
    bcnt_t              w_bcnt_nxt;

    assign w_tc        = (r_div == c_DIV_W'(SCLK_HALF - 1));
    assign fall        = w_tc & r_sclk;
    assign w_bcnt_nxt  = r_bcnt + bcnt_t'(1);
    // The fall that wraps bcnt to 0 opens a new frame
    assign frame_start = fall & (r_bcnt == '1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_div  <= '0;
            r_sclk <= 1'b0;
            r_lrck <= 1'b1;
            r_bcnt <= '1;
        end else begin
            if (w_tc) begin
                r_div  <= '0;
                r_sclk <= ~r_sclk;
            end else begin
                r_div  <= r_div + c_DIV_W'(1);
            end
            if (fall) begin
                r_bcnt <= w_bcnt_nxt;
                if (w_bcnt_nxt == bcnt_t'(0)) begin
                    r_lrck <= 1'b0;
                end else if (w_bcnt_nxt == bcnt_t'(I2S_SLOT_BITS)) begin
                    r_lrck <= 1'b1;
                end
            end
        end
    end

    assign sclk = r_sclk;
    assign lrck = r_lrck;
    assign bcnt = r_bcnt;

endmodule
`default_nettype wire

// File: rtl/i2s_tx.sv
`default_nettype none
// ============================================================================
// Module      : i2s_tx
// Description : I2S master transmitter, stereo samples in, serial sdo out.
// Revision    : 1.0 - initial release
// ============================================================================
module i2s_tx
    import sample_pkg::*;
    import i2s_pkg::*;
#(
    parameter int SCLK_HALF  = 2,
    parameter int DATA_WIDTH = 24
) (
    input  logic   clk,
    input  logic   rst,
    axis_if.slave  axis_tx,
    output logic   sclk,
    output logic   lrck,
    output logic   sdo,
    output logic   underrun
);

    logic                  w_fall;
    logic                  w_fs;
    bcnt_t                 w_bcnt;
    bcnt_t                 w_bcnt_nxt;
    logic                  w_xfer;
    logic                  w_full_nxt;
    logic                  w_load_hold;
    logic [DATA_WIDTH-1:0] w_in_lc;
    logic [DATA_WIDTH-1:0] w_in_rc;
    logic [DATA_WIDTH-1:0] w_word;
    logic [I2S_SLOT_BITS-1:0] w_slot;

    logic                  r_ok;
    logic                  r_hold_full;
    logic [DATA_WIDTH-1:0] r_hold_lc;
    logic [DATA_WIDTH-1:0] r_hold_rc;
    logic [DATA_WIDTH-1:0] r_frm_lc;
    logic [DATA_WIDTH-1:0] r_frm_rc;
    logic                  r_sdo;
    logic                  r_underrun;

    i2s_clkgen #(
        .SCLK_HALF   (SCLK_HALF)
    ) u_clkgen (
        .clk         (clk),
        .rst         (rst),
        .sclk        (sclk),
        .lrck        (lrck),
        .bcnt        (w_bcnt),
        .fall        (w_fall),
        .frame_start (w_fs)
    );

    assign w_in_lc    = axis_tx.data.lc[DATA_WIDTH-1:0];
    assign w_in_rc    = axis_tx.data.rc[DATA_WIDTH-1:0];
    assign w_xfer     = axis_tx.vld & r_ok;
    assign w_bcnt_nxt = w_bcnt + bcnt_t'(1);

    // A transfer landing on an empty-holding frame start bypasses into the frame
    always_comb begin
        w_full_nxt  = r_hold_full;
        w_load_hold = 1'b0;
        if (w_fs) begin
            w_full_nxt  = r_hold_full & w_xfer;
            w_load_hold = r_hold_full & w_xfer;
        end else if (w_xfer) begin
            w_full_nxt  = 1'b1;
            w_load_hold = 1'b1;
        end
    end

    // Slot image: bit 31 is the one-sclk delay, MSB at 30, zero tail below LSB
    assign w_word = w_bcnt_nxt[5] ? r_frm_rc : r_frm_lc;
    assign w_slot = I2S_SLOT_BITS'(w_word) << (I2S_SLOT_BITS - 1 - DATA_WIDTH);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ok        <= 1'b0;
            r_hold_full <= 1'b0;
            r_hold_lc   <= '0;
            r_hold_rc   <= '0;
            r_frm_lc    <= '0;
            r_frm_rc    <= '0;
            r_sdo       <= 1'b0;
            r_underrun  <= 1'b0;
        end else begin
            r_hold_full <= w_full_nxt;
            r_ok        <= ~w_full_nxt;
            r_underrun  <= w_fs & ~r_hold_full & ~w_xfer;
            if (w_load_hold) begin
                r_hold_lc <= w_in_lc;
                r_hold_rc <= w_in_rc;
            end
            if (w_fs) begin
                if (r_hold_full) begin
                    r_frm_lc <= r_hold_lc;
                    r_frm_rc <= r_hold_rc;
                end else if (w_xfer) begin
                    r_frm_lc <= w_in_lc;
                    r_frm_rc <= w_in_rc;
                end else begin
                    r_frm_lc <= '0;
                    r_frm_rc <= '0;
                end
            end
            if (w_fall) begin
                r_sdo <= w_slot[~w_bcnt_nxt[4:0]];
            end
        end
    end

    assign axis_tx.ok = r_ok;
    assign sdo        = r_sdo;
    assign underrun   = r_underrun;

endmodule
`default_nettype wire

// File: tb/tb_i2s_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_i2s_tx
// Description : Self-checking bench for i2s_tx against a timeline model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_i2s_tx;

    localparam int H  = 2;
    localparam int DW = 24;
    localparam int SP = 2 * H;
    localparam int FR = 64 * SP;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic sclk, lrck, sdo, underrun;

    axis_if axis ();

    i2s_tx #(
        .SCLK_HALF  (H),
        .DATA_WIDTH (DW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .axis_tx  (axis),
        .sclk     (sclk),
        .lrck     (lrck),
        .sdo      (sdo),
        .underrun (underrun)
    );

    always #5 clk = ~clk;

    int          n_pass, n_total, und_seen, t, m_bcnt;
    bit          m_sclk, m_lrck, m_sdo, m_und, m_ok, m_full, m_xfer, m_fs, m_rise;
    logic [23:0] m_hl, m_hr, m_fl, m_fr;
    bit          rx_bits [64];
    bit          rx_valid;
    logic [47:0] exp_q [$];

    task automatic check(input string tag, input logic [47:0] obs, input logic [47:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h (t=%0d)", tag, obs, exp, t);
    endtask

    task automatic model_reset();
        t = 0; m_bcnt = 63;
        m_sclk = 0; m_lrck = 1; m_sdo = 0; m_und = 0; m_ok = 0; m_full = 0;
        m_hl = 0; m_hr = 0; m_fl = 0; m_fr = 0;
        rx_valid = 0;
        exp_q.delete();
    endtask

    task automatic decode_frame();
        logic [23:0] lw, rw;
        logic [47:0] e;
        bit pad;
        lw = 0; rw = 0;
        for (int p = 1; p <= DW; p++) begin
            lw = {lw[22:0], rx_bits[p]};
            rw = {rw[22:0], rx_bits[32+p]};
        end
        pad = rx_bits[0] | rx_bits[32];
        for (int p = DW + 1; p < 32; p++) pad = pad | rx_bits[p] | rx_bits[32+p];
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 48'hxxxx_xxxx_xxxx;
        check("frame_data", {lw, rw}, e);
        check("frame_pad", 48'(pad), 48'd0);
    endtask

    // Timeline model: sclk/lrck/bcnt from the edge count since release,
    // data from a one-deep holding stage plus the current frame words.
    task automatic tick();
        logic [23:0] w;
        int p;
        @(posedge clk);
        m_xfer = 0; m_fs = 0; m_rise = 0; m_und = 0;
        if (!rst) begin
            m_xfer = axis.vld && m_ok;
            t++;
            if (t % H == 0) m_sclk = ((t / H) % 2) == 1;
            m_rise = (t % SP == H);
            if (t % SP == 0) begin
                m_bcnt = (t / SP - 1) % 64;
                m_lrck = (m_bcnt >= 32);
                if (m_bcnt == 0) begin
                    m_fs = 1;
                    if (rx_valid) decode_frame();
                    rx_valid = 1;
                    if (m_full) begin
                        m_fl = m_hl; m_fr = m_hr;
                        m_full = m_xfer;
                        if (m_xfer) begin m_hl = axis.data.lc; m_hr = axis.data.rc; end
                    end else if (m_xfer) begin
                        m_fl = axis.data.lc; m_fr = axis.data.rc;
                    end else begin
                        m_fl = 0; m_fr = 0; m_und = 1;
                    end
                    exp_q.push_back({m_fl, m_fr});
                end else if (m_xfer) begin
                    m_hl = axis.data.lc; m_hr = axis.data.rc; m_full = 1;
                end
                p = m_bcnt % 32;
                w = (m_bcnt < 32) ? m_fl : m_fr;
                m_sdo = (p >= 1 && p <= DW) ? w[DW-p] : 1'b0;
            end else if (m_xfer) begin
                m_hl = axis.data.lc; m_hr = axis.data.rc; m_full = 1;
            end
            m_ok = !m_full;
        end
        @(negedge clk);
        if (m_rise) rx_bits[m_bcnt] = sdo;
        if (underrun) und_seen++;
        check("sclk", 48'(sclk), 48'(m_sclk));
        check("lrck", 48'(lrck), 48'(m_lrck));
        check("sdo", 48'(sdo), 48'(m_sdo));
        check("underrun", 48'(underrun), 48'(m_und));
        check("ok", 48'(axis.ok), 48'(m_ok));
    endtask

    task automatic send(input logic [23:0] lc, input logic [23:0] rc, input bit keep);
        axis.data.lc = lc;
        axis.data.rc = rc;
        axis.vld     = 1'b1;
        for (int i = 0; i < 3 * FR; i++) begin
            tick();
            if (m_xfer) break;
        end
        check("send_accept", 48'(m_xfer), 48'd1);
        if (!keep) axis.vld = 1'b0;
    endtask

    task automatic wait_fs();
        for (int i = 0; i < 2 * FR; i++) begin
            tick();
            if (m_fs) break;
        end
        check("frame_start_seen", 48'(m_fs), 48'd1);
    endtask

    initial begin
        n_pass = 0; n_total = 0; und_seen = 0;
        axis.vld  = 1'b0;
        axis.data = '0;
        rst = 1'b1;
        model_reset();
        repeat (10) tick();
        rst = 1'b0;

        // Known sample straight after release lands in frame 0
        send(24'hA5F00F, 24'h123456, 1'b0);
        wait_fs();
        und_seen = 0;
        repeat (FR - 1) tick();
        check("no_underrun_frame0", 48'(und_seen), 48'd0);
        tick();

        // Three idle frames
        und_seen = 0;
        repeat (3 * FR) tick();
        check("underrun_pulses", 48'(und_seen), 48'd3);

        // Backpressure with vld held high
        send(24'd1, 24'($urandom), 1'b1);
        send(24'd2, 24'($urandom), 1'b1);
        send(24'd3, 24'($urandom), 1'b0);
        repeat (4) wait_fs();

        // Bypass: vld rises in the frame-start clk with holding empty
        for (int i = 0; i < FR && (t % FR) != SP - 1; i++) tick();
        axis.data.lc = 24'($urandom);
        axis.data.rc = 24'($urandom);
        axis.vld     = 1'b1;
        tick();
        axis.vld = 1'b0;
        check("bypass_no_underrun", 48'(underrun), 48'd0);

        // Fill holding, then reset mid-frame
        send(24'($urandom), 24'($urandom), 1'b0);
        for (int i = 0; i < FR && m_bcnt != 10; i++) tick();
        check("reset_point_bcnt", 48'(m_bcnt), 48'd10);
        #1 rst = 1'b1;
        #1;
        check("async_sclk", 48'(sclk), 48'd0);
        check("async_lrck", 48'(lrck), 48'd1);
        check("async_sdo", 48'(sdo), 48'd0);
        check("async_ok", 48'(axis.ok), 48'd0);
        model_reset();
        repeat (5) tick();
        rst = 1'b0;
        wait_fs();
        check("reset_frame0_underrun", 48'(underrun), 48'd1);
        wait_fs();

        // Random traffic, vld may drop without a transfer
        for (int i = 0; i < 6 * FR; i++) begin
            axis.vld     = ($urandom_range(0, 7) == 0);
            axis.data.lc = 24'($urandom);
            axis.data.rc = 24'($urandom);
            tick();
        end
        axis.vld = 1'b0;
        repeat (3) wait_fs();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
